// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the SRP16 instruction fetch sequencer.
// State encodings plus parameter defaults used by fetch_unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD1  = 2'd1,
    S_RD2  = 2'd2
  } fstate_e;

  localparam int unsigned EXT_BIT_DEF = 15;
  localparam int unsigned RST_PC_DEF  = 0;

endpackage

// File: rtl/fetch_unit_prefetch_buf.sv
// One-entry prefetch buffer holding the word read ahead at an address.
// Only built when FETCH_PREFETCH_EN is defined.
`ifdef FETCH_PREFETCH_EN
module prefetch_buf #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          ld_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_data_i,
  input  logic [AW-1:0] cmp_addr_i,
  output logic          valid_o,
  output logic          hit_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (ld_i) begin
      valid_d = 1'b1;
      addr_d  = ld_addr_i;
      data_d  = ld_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign hit_o   = valid_q && (addr_q == cmp_addr_i);
  assign data_o  = data_q;

endmodule
`endif

// File: rtl/fetch_unit.sv
// SRP16 fetch sequencer: owns the PC, reads words, strobes them into the IR.
// FETCH_PREFETCH_EN adds a one-entry read-ahead buffer used while idle.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned EXT_BIT = EXT_BIT_DEF,
  parameter logic [AW-1:0] RST_PC = AW'(RST_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_din,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          fetch_done,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ir_din,
  output logic          ir_write,
  output logic          ir_writeu
);

  fstate_e       state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_din_q, ir_din_d;
  logic          ir_write_q, ir_write_d;
  logic          ir_writeu_q, ir_writeu_d;
  logic          done_q, done_d;
  logic          mem_rd_q, mem_rd_d;
  logic          busy_q, busy_d;
  logic          ack;
  logic          take1;
  logic [DW-1:0] word1;

`ifdef FETCH_PREFETCH_EN
  logic          pf_clr, pf_ld, pf_valid, pf_hit;
  logic [DW-1:0] pf_data;

  prefetch_buf #(
    .AW(AW),
    .DW(DW)
  ) u_pf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (pf_clr),
    .ld_i      (pf_ld),
    .ld_addr_i (pc_q),
    .ld_data_i (mem_rdata),
    .cmp_addr_i(pc_q),
    .valid_o   (pf_valid),
    .hit_o     (pf_hit),
    .data_o    (pf_data)
  );
`endif

  // an ack only counts against a request we are actually driving
  assign ack = mem_ack && mem_rd_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_din_d    = ir_din_q;
    ir_write_d  = 1'b0;
    ir_writeu_d = 1'b0;
    done_d      = 1'b0;
    take1       = 1'b0;
    word1       = mem_rdata;
`ifdef FETCH_PREFETCH_EN
    pf_clr      = 1'b0;
    pf_ld       = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pc_load) begin
          pc_d = pc_din;
`ifdef FETCH_PREFETCH_EN
          pf_clr = 1'b1;
`endif
        end else if (fetch_req) begin
`ifdef FETCH_PREFETCH_EN
          if (pf_hit) begin
            take1  = 1'b1;
            word1  = pf_data;
            pf_clr = 1'b1;
          end else begin
            state_d = S_RD1;
          end
`else
          state_d = S_RD1;
`endif
        end
`ifdef FETCH_PREFETCH_EN
        else if (ack) begin
          pf_ld = 1'b1;
        end
`endif
      end
      S_RD1: begin
        if (pc_load) begin
          pc_d    = pc_din;
          state_d = S_IDLE;
`ifdef FETCH_PREFETCH_EN
          pf_clr  = 1'b1;
`endif
        end else if (ack) begin
          take1 = 1'b1;
        end
      end
      S_RD2: begin
        if (pc_load) begin
          pc_d    = pc_din;
          state_d = S_IDLE;
`ifdef FETCH_PREFETCH_EN
          pf_clr  = 1'b1;
`endif
        end else if (ack) begin
          ir_din_d    = mem_rdata;
          ir_writeu_d = 1'b1;
          done_d      = 1'b1;
          pc_d        = pc_q + AW'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take1) begin
      ir_din_d   = word1;
      ir_write_d = 1'b1;
      pc_d       = pc_q + AW'(1);
      if (word1[EXT_BIT]) begin
        state_d = S_RD2;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    busy_d   = (state_d != S_IDLE);
    mem_rd_d = busy_d;
`ifdef FETCH_PREFETCH_EN
    // read ahead while idle until the buffer holds the word at pc
    if (state_q == S_IDLE && state_d == S_IDLE &&
        !pc_load && !fetch_req && !pf_valid && !pf_ld) begin
      mem_rd_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RST_PC;
      ir_din_q    <= '0;
      ir_write_q  <= 1'b0;
      ir_writeu_q <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_din_q    <= ir_din_d;
      ir_write_q  <= ir_write_d;
      ir_writeu_q <= ir_writeu_d;
      done_q      <= done_d;
      mem_rd_q    <= mem_rd_d;
      busy_q      <= busy_d;
    end
  end

  assign pc         = pc_q;
  assign mem_addr   = pc_q;
  assign busy       = busy_q;
  assign fetch_done = done_q;
  assign mem_rd     = mem_rd_q;
  assign ir_din     = ir_din_q;
  assign ir_write   = ir_write_q;
  assign ir_writeu  = ir_writeu_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory, random waits,
// directed reset/latency/extended/wrap/abort cases then a random mix.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_din = '0;
  logic [15:0] pc;
  logic        busy, fetch_done, mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ir_din;
  logic        ir_write, ir_writeu;

  fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_req (fetch_req),
    .pc_load   (pc_load),
    .pc_din    (pc_din),
    .pc        (pc),
    .busy      (busy),
    .fetch_done(fetch_done),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir_din    (ir_din),
    .ir_write  (ir_write),
    .ir_writeu (ir_writeu)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic        u;
    logic        done;
    logic [15:0] pc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mem [0:65535];
  logic [15:0] mpc = '0;
  int          tests = 0;
  int          fails = 0;
  int          fixed_wait = -1;
  int          wcnt = -1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // memory: answers a held request after a chosen number of wait cycles
  always @(negedge clk) begin
    if (mem_rd !== 1'b1) begin
      wcnt      = -1;
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
    end else begin
      if (wcnt < 0)
        wcnt = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
      if (wcnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        wcnt      = -1;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        wcnt--;
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (ir_write || ir_writeu) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", {62'b0, ir_write, ir_writeu}, 64'd0);
        end else begin
          e = q.pop_front();
          check("strobe",
                {29'b0, ir_din, ir_writeu, ir_write, fetch_done, pc},
                {29'b0, e.din, e.u, !e.u, e.done, e.pc});
        end
      end else if (fetch_done) begin
        check("lone_done", {63'b0, fetch_done}, 64'd0);
      end
      if (mem_rd) check("mem_addr", {48'b0, mem_addr}, {48'b0, pc});
    end
  end

  // instruction-level model: one or two words taken from mem at the PC
  task automatic model_fetch();
    exp_t e;
    e.din  = mem[mpc];
    mpc    = mpc + 16'd1;
    e.u    = 1'b0;
    e.done = !e.din[15];
    e.pc   = mpc;
    q.push_back(e);
    if (e.din[15]) begin
      e.din  = mem[mpc];
      mpc    = mpc + 16'd1;
      e.u    = 1'b1;
      e.done = 1'b1;
      e.pc   = mpc;
      q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    fetch_req = 1'b0;
    pc_load   = 1'b0;
    @(posedge clk);
    q.delete();
    mpc = 16'h0000;
    #1;
    check("reset_pc", {48'b0, pc}, 64'd0);
    check("reset_ctl",
          {58'b0, mem_rd, ir_write, ir_writeu, fetch_done, busy, 1'b0},
          64'd0);
    check("reset_ir_din", {48'b0, ir_din}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_pc(input logic [15:0] v);
    @(negedge clk);
    pc_load = 1'b1;
    pc_din  = v;
    @(negedge clk);
    pc_load = 1'b0;
    mpc     = v;
    q.delete();
    check("pc_load", {48'b0, pc}, {48'b0, v});
  endtask

  task automatic issue_fetch();
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    fetch_req = 1'b1;
    model_fetch();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      fetch_req = busy && ($urandom_range(0, 3) == 0);
      if (q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    fetch_req = 1'b0;
    if (!ok) begin
      check("fetch_timeout", {31'b0, busy, 32'(q.size())}, 64'd0);
      do_reset();
    end
  endtask

  task automatic interrupt_fetch(input bit use_reset);
    logic [15:0] v;
    v = 16'($urandom);
    @(negedge clk);
    fetch_req = 1'b1;
    model_fetch();
    @(negedge clk);
    fetch_req = 1'b0;
    repeat ($urandom_range(0, 4)) @(negedge clk);
    if (use_reset) begin
      do_reset();
    end else begin
      pc_load = 1'b1;
      pc_din  = v;
      @(posedge clk);
      q.delete();
      mpc = v;
      #1;
      check("abort_state", {45'b0, busy, mem_rd, ir_writeu, pc},
            {45'b0, 3'b000, v});
      @(negedge clk);
      pc_load = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0000] = 16'h0F0F;
    mem[16'h0004] = 16'h8012;
    mem[16'h0005] = 16'h0003;
    mem[16'h0007] = 16'h1234;
    mem[16'h0008] = 16'h0055;
    mem[16'h0020] = 16'h8012;
    mem[16'h0021] = 16'h0003;
    mem[16'hFFFF] = 16'h9ABC;

    do_reset();

    fixed_wait = 0;
`ifndef FETCH_PREFETCH_EN
    @(negedge clk);
    fetch_req = 1'b1;
    model_fetch();
    @(posedge clk);
    #1;
    check("rd1_entry", {62'b0, busy, mem_rd}, 64'd3);
    @(negedge clk);
    fetch_req = 1'b0;
    @(posedge clk);
    #1;
    check("single_latency", {60'b0, ir_write, fetch_done, mem_rd, busy},
          64'hC);
    @(posedge clk);
    #1;
    check("single_pulse", {62'b0, ir_write, fetch_done}, 64'd0);
`else
    issue_fetch();
`endif
    check("pc_single", {48'b0, pc}, 64'd1);

    load_pc(16'h0004);
    fixed_wait = 2;
    issue_fetch();
    check("pc_ext", {48'b0, pc}, 64'd6);

    load_pc(16'hFFFF);
    fixed_wait = 1;
    issue_fetch();
    check("pc_wrap", {48'b0, pc}, 64'd1);

`ifndef FETCH_PREFETCH_EN
    load_pc(16'h0020);
    fixed_wait = 0;
    @(negedge clk);
    fetch_req = 1'b1;
    e.din = 16'h8012; e.u = 1'b0; e.done = 1'b0; e.pc = 16'h0021;
    q.push_back(e);
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    pc_load = 1'b1;
    pc_din  = 16'h0040;
    @(posedge clk);
    mpc = 16'h0040;
    #1;
    check("abort_rd2",
          {44'b0, busy, mem_rd, ir_writeu, fetch_done, pc},
          {44'b0, 4'b0000, 16'h0040});
    check("abort_first_seen", 64'(q.size()), 64'd0);
    @(negedge clk);
    pc_load = 1'b0;
    @(posedge clk);
    #1;
    check("abort_idle", {62'b0, busy, ir_writeu}, 64'd0);
`else
    load_pc(16'h0007);
    fixed_wait = 0;
    issue_fetch();
    repeat (6) @(negedge clk);
    check("pf_filled", {63'b0, dut.u_pf.valid_o}, 64'd1);
    check("pf_idle_quiet", {63'b0, mem_rd}, 64'd0);
    fetch_req = 1'b1;
    model_fetch();
    @(posedge clk);
    #1;
    check("pf_hit", {61'b0, ir_write, mem_rd, busy}, 64'd4);
    @(negedge clk);
    fetch_req = 1'b0;
    load_pc(16'h0008);
    check("pf_cleared", {63'b0, dut.u_pf.valid_o}, 64'd0);
`endif

    fixed_wait = -1;
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        issue_fetch();
      end else if (r <= 7) begin
        if ($urandom_range(0, 3) == 0)
          load_pc(16'hFFFE + 16'($urandom_range(0, 1)));
        else
          load_pc(16'($urandom));
      end else if (r == 8) begin
        interrupt_fetch(1'b0);
      end else begin
        interrupt_fetch(1'b1);
      end
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
